// File: rtl/fu_seq_pkg.sv
// Shared types and constants for the function-unit sequencer slice.
// The command record is latched once per op and drives both the regfile reads and the FU controls.
package fu_seq_pkg;

  localparam int NREG = 8;
  localparam int W    = 32;
  localparam int RIW  = 3;
  localparam int SHW  = 5;

  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic           mf;
    logic [2:0]     sel;
    logic [SHW-1:0] shamt;
    logic           t;
    logic [RIW-1:0] ra;
    logic [RIW-1:0] rb;
    logic [RIW-1:0] rd;
    logic           wb;
  } cmd_s;

endpackage

// File: rtl/fu_sequencer_if.sv
// Command, preload and FU-side signals of the sequencer.
// slave = sequencer view; master = command source plus FU instance.
interface fu_sequencer_if;
  import fu_seq_pkg::*;

  logic           cmd_valid;
  logic           cmd_ready;
  logic           cmd_mf;
  logic [2:0]     cmd_sel;
  logic [SHW-1:0] cmd_shamt;
  logic           cmd_t;
  logic [RIW-1:0] cmd_ra;
  logic [RIW-1:0] cmd_rb;
  logic [RIW-1:0] cmd_rd;
  logic           cmd_wb;

  logic           ld_valid;
  logic           ld_ready;
  logic [RIW-1:0] ld_addr;
  logic [W-1:0]   ld_data;

  logic [W-1:0]   fu_a;
  logic [W-1:0]   fu_b;
  logic [2:0]     fu_sel;
  logic [SHW-1:0] fu_shamt;
  logic           fu_t;
  logic           fu_mf;
  logic [W-1:0]   fu_out;
  logic           fu_v;
  logic           fu_c;
  logic           fu_n;
  logic           fu_z;

  logic           done;
  logic [W-1:0]   result;
  logic [3:0]     flags;

  modport slave (
    input  cmd_valid, cmd_mf, cmd_sel, cmd_shamt, cmd_t, cmd_ra, cmd_rb, cmd_rd, cmd_wb,
    output cmd_ready,
    input  ld_valid, ld_addr, ld_data,
    output ld_ready,
    output fu_a, fu_b, fu_sel, fu_shamt, fu_t, fu_mf,
    input  fu_out, fu_v, fu_c, fu_n, fu_z,
    output done, result, flags
  );

  modport master (
    output cmd_valid, cmd_mf, cmd_sel, cmd_shamt, cmd_t, cmd_ra, cmd_rb, cmd_rd, cmd_wb,
    input  cmd_ready,
    output ld_valid, ld_addr, ld_data,
    input  ld_ready,
    input  fu_a, fu_b, fu_sel, fu_shamt, fu_t, fu_mf,
    output fu_out, fu_v, fu_c, fu_n, fu_z,
    input  done, result, flags
  );

endinterface

// File: rtl/fu_regfile.sv
// NREG x W register file: two async read ports, one sync write port.
// r0 is hardwired to zero on read and never written.
module fu_regfile
  import fu_seq_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic [RIW-1:0] i_ra_addr,
  input  logic [RIW-1:0] i_rb_addr,
  output logic [W-1:0]   o_ra_data,
  output logic [W-1:0]   o_rb_data,
  input  logic           i_we,
  input  logic [RIW-1:0] i_waddr,
  input  logic [W-1:0]   i_wdata
);

  logic [W-1:0] r_mem [NREG];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_ra_data = (i_ra_addr == '0) ? '0 : r_mem[i_ra_addr];
  assign o_rb_data = (i_rb_addr == '0) ? '0 : r_mem[i_rb_addr];

endmodule

// File: rtl/fu_sequencer.sv
// Four-state controller sequencing one op through the shared FU:
// latch command, read operands, capture result/flags with optional writeback, pulse done.
module fu_sequencer
  import fu_seq_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  fu_sequencer_if.slave  bus
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_READ = ST_READ;
  localparam logic [1:0] S_EXEC = ST_EXEC;
  localparam logic [1:0] S_DONE = ST_DONE;

  logic [1:0]     r_state;
  cmd_s           r_cmd;
  logic [W-1:0]   r_fu_a;
  logic [W-1:0]   r_fu_b;
  logic [2:0]     r_fu_sel;
  logic [SHW-1:0] r_fu_shamt;
  logic           r_fu_t;
  logic           r_fu_mf;
  logic [W-1:0]   r_result;
  logic [3:0]     r_flags;

  logic           w_cmd_ready;
  logic           w_ld_ready;
  logic           w_cmd_fire;
  logic           w_ld_fire;
  logic           w_wb_we;
  logic           w_we;
  logic [RIW-1:0] w_waddr;
  logic [W-1:0]   w_wdata;
  logic [W-1:0]   w_rd_a;
  logic [W-1:0]   w_rd_b;

  // Handshakes look only at state and cmd_valid so they never loop through the FU.
  assign w_cmd_ready = (r_state == S_IDLE);
  assign w_ld_ready  = (r_state == S_IDLE) && !bus.cmd_valid;
  assign w_cmd_fire  = bus.cmd_valid && w_cmd_ready;
  assign w_ld_fire   = bus.ld_valid && w_ld_ready;

  // Writeback and preload are mutually exclusive by state, so a simple priority mux suffices.
  assign w_wb_we = (r_state == S_EXEC) && r_cmd.wb;
  assign w_we    = w_wb_we || w_ld_fire;
  assign w_waddr = w_wb_we ? r_cmd.rd  : bus.ld_addr;
  assign w_wdata = w_wb_we ? bus.fu_out : bus.ld_data;

  fu_regfile u_regfile (
    .clk       (clk),
    .reset     (reset),
    .i_ra_addr (r_cmd.ra),
    .i_rb_addr (r_cmd.rb),
    .o_ra_data (w_rd_a),
    .o_rb_data (w_rd_b),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cmd      <= '0;
      r_fu_a     <= '0;
      r_fu_b     <= '0;
      r_fu_sel   <= '0;
      r_fu_shamt <= '0;
      r_fu_t     <= 1'b0;
      r_fu_mf    <= 1'b0;
      r_result   <= '0;
      r_flags    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cmd_fire) begin
            r_cmd.mf    <= bus.cmd_mf;
            r_cmd.sel   <= bus.cmd_sel;
            r_cmd.shamt <= bus.cmd_shamt;
            r_cmd.t     <= bus.cmd_t;
            r_cmd.ra    <= bus.cmd_ra;
            r_cmd.rb    <= bus.cmd_rb;
            r_cmd.rd    <= bus.cmd_rd;
            r_cmd.wb    <= bus.cmd_wb;
            r_state     <= S_READ;
          end
        end
        S_READ: begin
          r_fu_a     <= w_rd_a;
          r_fu_b     <= w_rd_b;
          r_fu_sel   <= r_cmd.sel;
          r_fu_shamt <= r_cmd.shamt;
          r_fu_t     <= r_cmd.t;
          r_fu_mf    <= r_cmd.mf;
          r_state    <= S_EXEC;
        end
        S_EXEC: begin
          r_result        <= bus.fu_out;
          r_flags[FLAG_V] <= bus.fu_v;
          r_flags[FLAG_C] <= bus.fu_c;
          r_flags[FLAG_N] <= bus.fu_n;
          r_flags[FLAG_Z] <= bus.fu_z;
          r_state         <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.ld_ready  = w_ld_ready;
  assign bus.fu_a      = r_fu_a;
  assign bus.fu_b      = r_fu_b;
  assign bus.fu_sel    = r_fu_sel;
  assign bus.fu_shamt  = r_fu_shamt;
  assign bus.fu_t      = r_fu_t;
  assign bus.fu_mf     = r_fu_mf;
  assign bus.done      = (r_state == S_DONE);
  assign bus.result    = r_result;
  assign bus.flags     = r_flags;

endmodule
